// File: rtl/acia_tx_fifo.sv
// Transmit byte FIFO between the ACIA register interface and the serial shifter.
// Drains one byte per tx_start/tx_busy handshake; a write is visible to the shifter one cycle later at the earliest.
module acia_tx_fifo #(
  parameter int AW       = 4,
  parameter int BUSY_TMO = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [7:0]    wr_dat,
  input  logic          wr_en,
  input  logic          flush,
  input  logic          tx_busy,
  output logic [7:0]    tx_dat,
  output logic          tx_start,
  output logic          fifo_full,
  output logic          fifo_empty,
  output logic [AW:0]   fifo_count,
  output logic          overrun
);

  localparam int DEPTH = 1 << AW;
  localparam int TW    = $clog2(BUSY_TMO + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   timer, timer_nxt;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            pop;
  logic            wr_acc;
  logic            wr_drop;

  assign fifo_count = count;
  assign fifo_full  = (count == (AW+1)'(DEPTH));
  assign fifo_empty = (count == '0);

  // A simultaneous pop frees the slot being written, so a full FIFO can still accept.
  assign wr_acc  = wr_en && !flush && (!fifo_full || pop);
  assign wr_drop = wr_en && !flush && fifo_full && !pop;

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0 && !tx_busy && !flush) begin
          pop       = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        timer_nxt = '0;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (timer == TW'(BUSY_TMO - 1)) begin
          // Shifter never acknowledged; the byte is considered sent.
          state_nxt = IDLE;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      timer    <= '0;
      tx_start <= 1'b0;
      tx_dat   <= 8'h00;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      tx_start <= pop;
      if (pop) tx_dat <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_drop) overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_dat;
  end

endmodule

// File: tb/tb_acia_tx_fifo.sv
// Directed bench for acia_tx_fifo: vector table for single-byte handshakes, then
// hand-written burst, overrun, full-with-pop, flush and async-reset sequences.
module tb_acia_tx_fifo;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  wr_dat;
  logic        wr_en;
  logic        flush;
  logic        tx_busy;
  logic [7:0]  tx_dat;
  logic        tx_start;
  logic        fifo_full;
  logic        fifo_empty;
  logic [4:0]  fifo_count;
  logic        overrun;

  logic        tb_busy;
  logic        model_en;
  logic        model_busy;
  int          mcnt;
  int          busy_len;

  int checks = 0;
  int errors = 0;
  logic [7:0] txq[$];

  always #5 clk = ~clk;

  assign tx_busy = model_en ? model_busy : tb_busy;

  acia_tx_fifo #(.AW(4), .BUSY_TMO(3)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_dat     (wr_dat),
    .wr_en      (wr_en),
    .flush      (flush),
    .tx_busy    (tx_busy),
    .tx_dat     (tx_dat),
    .tx_start   (tx_start),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .fifo_count (fifo_count),
    .overrun    (overrun)
  );

  // Shifter model: busy for busy_len cycles starting the edge after tx_start.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      model_busy <= 1'b0;
      mcnt       <= 0;
    end else if (model_busy) begin
      if (mcnt == busy_len - 1) model_busy <= 1'b0;
      mcnt <= mcnt + 1;
    end else if (tx_start && model_en) begin
      model_busy <= 1'b1;
      mcnt       <= 0;
    end
  end

  always @(negedge clk) begin
    if (reset_n && tx_start) begin
      txq.push_back(tx_dat);
      checks++;
      if (tx_busy) begin
        errors++;
        $display("FAIL start_while_busy: tx_start=1 with tx_busy=%0b, required tx_busy=0", tx_busy);
      end
    end
  end

  typedef struct {
    logic       wr_en;
    logic [7:0] wr_dat;
    logic       flush;
    logic       busy;
    logic       e_start;
    logic [7:0] e_dat;
    logic [4:0] e_cnt;
    logic       e_full;
    logic       e_empty;
    logic       e_ovr;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pulses(input int n, input int budget, input string name);
    int k = 0;
    while (txq.size() < n && k < budget) begin
      step();
      k++;
    end
    chk(name, 32'(txq.size()), 32'(n));
  endtask

  task automatic wait_model_idle();
    int k = 0;
    step();
    step();
    while (model_busy && k < 5000) begin
      step();
      k++;
    end
    chk("model_idle", 32'(model_busy), 32'd0);
    repeat (3) step();
  endtask

  initial begin
    logic [7:0] exp_b;

    // Single bytes with tx_busy tied low: 0x41, then 0x55/0xAA back to back.
    tbl[0]  = '{1'b1, 8'h41, 1'b0, 1'b0,  1'b0, 8'h00, 5'd1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b0,  1'b1, 8'h41, 5'd0, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0,  1'b0, 8'h41, 5'd0, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b0,  1'b0, 8'h41, 5'd0, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0,  1'b0, 8'h41, 5'd0, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0,  1'b0, 8'h41, 5'd0, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 8'h55, 1'b0, 1'b0,  1'b0, 8'h41, 5'd1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 8'hAA, 1'b0, 1'b0,  1'b1, 8'h55, 5'd1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b0,  1'b0, 8'h55, 5'd1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0,  1'b0, 8'h55, 5'd1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0,  1'b0, 8'h55, 5'd1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0,  1'b0, 8'h55, 5'd1, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b0,  1'b1, 8'hAA, 5'd0, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b0,  1'b0, 8'hAA, 5'd0, 1'b0, 1'b1, 1'b0};

    reset_n  = 1'b0;
    wr_en    = 1'b0;
    wr_dat   = 8'h00;
    flush    = 1'b0;
    tb_busy  = 1'b0;
    model_en = 1'b0;
    busy_len = 1390;
    repeat (2) step();
    chk("reset_state", 32'({tx_start, tx_dat, fifo_count, fifo_full, fifo_empty, overrun}),
        32'({1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0}));
    reset_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      wr_en   = tbl[i].wr_en;
      wr_dat  = tbl[i].wr_dat;
      flush   = tbl[i].flush;
      tb_busy = tbl[i].busy;
      step();
      chk($sformatf("vec%0d", i),
          32'({tx_start, tx_dat, fifo_count, fifo_full, fifo_empty, overrun}),
          32'({tbl[i].e_start, tbl[i].e_dat, tbl[i].e_cnt, tbl[i].e_full, tbl[i].e_empty, tbl[i].e_ovr}));
    end
    wr_en = 1'b0;
    repeat (4) step();

    // Burst of 16 bytes into a slow shifter.
    txq.delete();
    busy_len = 1390;
    model_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_en  = 1'b1;
      wr_dat = 8'(8'h30 + i);
      step();
    end
    wr_en = 1'b0;
    chk("burst_count", 32'(fifo_count), 32'd15);
    chk("burst_not_full", 32'(fifo_full), 32'd0);
    wait_pulses(16, 25000, "burst_pulses");
    for (int i = 0; i < 16; i++) begin
      exp_b = 8'(8'h30 + i);
      chk($sformatf("burst_byte%0d", i), (i < txq.size()) ? 32'(txq[i]) : 32'hFFFF_FFFF, 32'(exp_b));
    end
    wait_model_idle();

    // Fill with the shifter busy, then overflow with 0xEE, then flush.
    model_en = 1'b0;
    tb_busy  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_en  = 1'b1;
      wr_dat = 8'(8'hA0 + i);
      step();
    end
    chk("fill_count", 32'(fifo_count), 32'd16);
    chk("fill_full", 32'(fifo_full), 32'd1);
    wr_dat = 8'hEE;
    step();
    wr_en = 1'b0;
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_count", 32'(fifo_count), 32'd16);
    wr_en  = 1'b1;
    wr_dat = 8'h77;
    flush  = 1'b1;
    step();
    wr_en = 1'b0;
    flush = 1'b0;
    chk("flush_state", 32'({fifo_count, overrun, fifo_empty}), 32'({5'd0, 1'b0, 1'b1}));

    // Full FIFO: pop and write in the same cycle.
    txq.delete();
    for (int i = 0; i < 16; i++) begin
      wr_en  = 1'b1;
      wr_dat = 8'(8'hC0 + i);
      step();
    end
    wr_dat  = 8'hEF;
    tb_busy = 1'b0;
    step();
    wr_en = 1'b0;
    chk("full_pop_count", 32'(fifo_count), 32'd16);
    chk("full_pop_ovr", 32'(overrun), 32'd0);
    chk("full_pop_start", 32'({tx_start, tx_dat}), 32'({1'b1, 8'hC0}));
    busy_len = 20;
    model_en = 1'b1;
    wait_pulses(17, 2000, "full_pop_pulses");
    for (int i = 0; i < 17; i++) begin
      exp_b = (i == 16) ? 8'hEF : 8'(8'hC0 + i);
      chk($sformatf("drain_byte%0d", i), (i < txq.size()) ? 32'(txq[i]) : 32'hFFFF_FFFF, 32'(exp_b));
    end
    wait_model_idle();

    // Flush in the cycle that would pop wins.
    model_en = 1'b0;
    tb_busy  = 1'b1;
    txq.delete();
    wr_en  = 1'b1;
    wr_dat = 8'h5A;
    step();
    wr_en = 1'b0;
    chk("pre_flush_count", 32'(fifo_count), 32'd1);
    tb_busy = 1'b0;
    flush   = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_prio", 32'({tx_start, fifo_count}), 32'({1'b0, 5'd0}));
    step();
    chk("flush_prio_after", 32'(tx_start), 32'd0);
    chk("flush_prio_nopulse", 32'(txq.size()), 32'd0);

    // Asynchronous reset with count 5 while the FSM waits for the frame to end.
    busy_len = 100;
    model_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_en  = 1'b1;
      wr_dat = 8'(8'h10 + i);
      step();
    end
    wr_en = 1'b0;
    chk("pre_reset_count", 32'(fifo_count), 32'd5);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset", 32'({tx_start, tx_dat, fifo_count, fifo_empty, overrun}),
        32'({1'b0, 8'h00, 5'd0, 1'b1, 1'b0}));
    model_en = 1'b0;
    step();
    reset_n = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
